target_game_core: RTL and testbench
===================================

Name: target_game_core

Overview:
Parameterised game-control core for the photo-sensor target wall. It replaces the fixed two-target logic in the game top level. The core supports NUM_CHANNELS simultaneously lit targets chosen from an external random source, and debounces and edge-detects photo-sensor hits. It also runs per-target timeouts with a lives counter, and produces the score for score_converter.

Parameters:
NUM_SENSORS, 10, number of photo sensors / target positions (2..16)
NUM_CHANNELS, 2, simultaneously active targets (1..NUM_SENSORS/2)
IDX_W, 4, target index width; 2^IDX_W <= 2*NUM_SENSORS required
SCORE_W, 32, score width
HIT_POINTS, 100, score added per hit
LIVES, 3, misses allowed before game over
TIMEOUT_CYCLES, 50000000, clocks a target stays lit before counting as a miss

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; starts/restarts a game from IDLE or OVER
photo_array  in  NUM_SENSORS  raw sensor inputs, active-low (0 = beam broken = hit)
rand_num  in  IDX_W  free-running random number from random_num_gen
target_idx  out  NUM_CHANNELS*IDX_W  lit target index per channel, channel 0 in LSBs
target_valid  out  NUM_CHANNELS  channel has a lit target
score  out  SCORE_W  current score
lives_left  out  3  remaining lives
hit_pulse  out  1  one-cycle pulse on any scored hit
miss_pulse  out  1  one-cycle pulse on any timeout
game_over  out  1  high in OVER

Behaviour:
- Reset (async, active-high):
  - FSM=IDLE; score=0; lives_left=LIVES; target_valid=0; target_idx=0; pulses=0; timers=0.
  - Synchroniser flops reset to all-ones (no spurious hit).
- Input sync: each photo_array bit passes through 2 flops. A hit event is sync2 low while prev (a third flop) is high.
  - Latency: photo low first sampled at edge N causes score update at edge N+3.
  - A held-low sensor scores once only.
- FSM states: IDLE, PLAY, OVER.
  - IDLE: start=1 -> PLAY. All channels are marked pending; score=0; lives_left=LIVES.
  - PLAY -> OVER when lives_left reaches 0.
  - OVER: all target_valid cleared; score frozen; game_over=1. start=1 -> PLAY with the same initialisation as IDLE.
- Assignment (PLAY only):
  - At most one channel is assigned per cycle: the lowest-index pending channel.
  - Candidate c = rand_num, minus NUM_SENSORS if rand_num >= NUM_SENSORS.
  - If c equals the target_idx of any valid channel, use c+1 (wrap NUM_SENSORS-1 -> 0).
  - If that value still collides, the channel stays pending and retries next cycle.
  - On success: target_idx set, target_valid=1, timer loaded with TIMEOUT_CYCLES.
- Hit:
  - A hit event on sensor s with a valid channel whose target_idx == s scores: score += HIT_POINTS.
  - That channel's valid is cleared and it becomes pending.
  - Multiple channels hit in the same cycle each add HIT_POINTS; hit_pulse is a single pulse.
  - A hit on an unlit sensor is ignored, with no penalty.
- Score saturates at 2^SCORE_W-1.
- Timeout:
  - Each valid channel's timer decrements every cycle; reaching 0 is a miss.
  - On a miss: valid cleared, channel pending, lives_left decremented by 1, miss_pulse=1.
  - Multiple misses in the same cycle decrement once per missed channel, floored at 0.
  - Hit and timeout on the same channel in the same cycle: the hit wins, with no life lost.
- The final miss moves the FSM to OVER on the same edge that lives_left reaches 0. Hits in that cycle are still scored.
- start held high while in PLAY has no effect.
- Reset mid-game returns immediately to the IDLE reset values.

Test Plan:
1. Reset, then start=1 with rand_num=3 -> channel 0 is lit at idx 3 after 1 cycle. Channel 1 is lit with idx 4 (collision bump) on the next cycle, with rand_num still 3.
2. Drive photo_array[3] low for 10 cycles while channel 0 is at 3 -> score=100 exactly 3 edges after the first low sample. A single hit_pulse; channel 0 is reassigned.
3. rand_num=13 with NUM_SENSORS=10 -> assigned idx 3. rand_num=9 while 9 is already lit -> idx 0 (wrap).
4. TIMEOUT_CYCLES=8, no hits -> miss_pulse after 8 cycles per channel; lives 3->2->... Game_over asserts on the edge lives reaches 0; target_valid=0; further sensor lows leave score unchanged.
5. Both lit sensors fall in the same cycle -> score +200, one hit_pulse. A hit coincident with timer expiry -> score +100, lives unchanged.
6. Assert reset mid-PLAY with score=300 -> score=0, target_valid=0, IDLE immediately (asynchronous). start in OVER restarts with score=0, lives=LIVES.

Source files
------------

// File: rtl/target_game_core.sv
// rtl/target_game_core.sv - game-control core for the photo-sensor target wall
// Lights NUM_CHANNELS targets from a random source, scores debounced sensor hits, runs per-target timeouts.
module target_game_core #(
  parameter int NUM_SENSORS    = 10,
  parameter int NUM_CHANNELS   = 2,
  parameter int IDX_W          = 4,
  parameter int SCORE_W        = 32,
  parameter int HIT_POINTS     = 100,
  parameter int LIVES          = 3,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_SENSORS-1:0]        photo_array,
  input  logic [IDX_W-1:0]              rand_num,
  output logic [NUM_CHANNELS*IDX_W-1:0] target_idx,
  output logic [NUM_CHANNELS-1:0]       target_valid,
  output logic [SCORE_W-1:0]            score,
  output logic [2:0]                    lives_left,
  output logic                          hit_pulse,
  output logic                          miss_pulse,
  output logic                          game_over
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [SCORE_W-1:0] PTS      = SCORE_W'(HIT_POINTS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t                   state_q, state_d;
  logic [NUM_SENSORS-1:0]   sync1_q, sync2_q, prev_q, hit_q;
  logic [NUM_SENSORS-1:0]   sync1_d, sync2_d, prev_d, hit_d;
  logic [IDX_W-1:0]         idx_q   [NUM_CHANNELS];
  logic [IDX_W-1:0]         idx_d   [NUM_CHANNELS];
  logic [TMR_W-1:0]         timer_q [NUM_CHANNELS];
  logic [TMR_W-1:0]         timer_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  valid_q, valid_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic [2:0]               lives_q, lives_d;
  logic                     hit_pulse_q, hit_pulse_d;
  logic                     miss_pulse_q, miss_pulse_d;

  logic [NUM_CHANNELS-1:0]  hit_ch, miss_ch;
  logic [IDX_W-1:0]         cand, alt, chosen;
  logic                     cand_used, alt_used, assign_ok, found;
  logic [SCORE_W:0]         sum;

  // Sensors are active-low; the registered hit stage fires once per falling edge.
  always_comb begin
    sync1_d = photo_array;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    hit_d   = ~sync2_q & prev_q;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    valid_d      = valid_q;
    score_d      = score_q;
    lives_d      = lives_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    hit_ch       = '0;
    miss_ch      = '0;
    cand         = rand_num;
    alt          = '0;
    chosen       = '0;
    cand_used    = 1'b0;
    alt_used     = 1'b0;
    assign_ok    = 1'b0;
    found        = 1'b0;
    sum          = '0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          valid_d = '0;
          score_d = '0;
          lives_d = 3'(LIVES);
          for (int ch = 0; ch < NUM_CHANNELS; ch++) timer_d[ch] = '0;
        end
      end

      S_PLAY: begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          if (valid_q[ch]) begin
            for (int s = 0; s < NUM_SENSORS; s++) begin
              if (hit_q[s] && idx_q[ch] == IDX_W'(s)) hit_ch[ch] = 1'b1;
            end
            // A hit on the expiry cycle takes precedence over the miss.
            miss_ch[ch] = !hit_ch[ch] && (timer_q[ch] <= TMR_W'(1));
            timer_d[ch] = timer_q[ch] - TMR_W'(1);
          end
        end

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          if (hit_ch[ch]) begin
            valid_d[ch] = 1'b0;
            sum         = {1'b0, score_d} + {1'b0, PTS};
            score_d     = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          end else if (miss_ch[ch]) begin
            valid_d[ch] = 1'b0;
            if (lives_d != 3'd0) lives_d = lives_d - 3'd1;
          end
        end
        hit_pulse_d  = |hit_ch;
        miss_pulse_d = |miss_ch;

        if (int'(rand_num) >= NUM_SENSORS) cand = rand_num - IDX_W'(NUM_SENSORS);
        alt = (int'(cand) == NUM_SENSORS - 1) ? '0 : cand + IDX_W'(1);
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          if (valid_q[ch] && idx_q[ch] == cand) cand_used = 1'b1;
          if (valid_q[ch] && idx_q[ch] == alt)  alt_used  = 1'b1;
        end
        assign_ok = !cand_used || !alt_used;
        chosen    = cand_used ? alt : cand;

        // Only the lowest pending channel is considered; on a double collision it retries.
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          if (!valid_q[ch] && !found) begin
            found = 1'b1;
            if (assign_ok) begin
              idx_d[ch]   = chosen;
              valid_d[ch] = 1'b1;
              timer_d[ch] = TMR_LOAD;
            end
          end
        end

        if (lives_d == 3'd0) begin
          state_d = S_OVER;
          valid_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= '1;
      sync2_q      <= '1;
      prev_q       <= '1;
      hit_q        <= '0;
      valid_q      <= '0;
      score_q      <= '0;
      lives_q      <= 3'(LIVES);
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        idx_q[ch]   <= '0;
        timer_q[ch] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      hit_q        <= hit_d;
      valid_q      <= valid_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        idx_q[ch]   <= idx_d[ch];
        timer_q[ch] <= timer_d[ch];
      end
    end
  end

  always_comb begin
    target_idx = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) target_idx[ch*IDX_W +: IDX_W] = idx_q[ch];
  end

  assign target_valid = valid_q;
  assign score        = score_q;
  assign lives_left   = lives_q;
  assign hit_pulse    = hit_pulse_q;
  assign miss_pulse   = miss_pulse_q;
  assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_target_game_core.sv
// tb/tb_target_game_core.sv - directed self-checking bench for target_game_core
// Expected scores/lives are queued with each stimulus and popped when hit_pulse/miss_pulse fire.
module tb_target_game_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  photo;
  logic [3:0]  rand_num;
  logic [7:0]  target_idx;
  logic [1:0]  target_valid;
  logic [31:0] score;
  logic [2:0]  lives_left;
  logic        hit_pulse, miss_pulse, game_over;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  logic [31:0] exp_score_q [$];
  logic [2:0]  exp_lives_q [$];

  target_game_core #(
    .NUM_SENSORS(10), .NUM_CHANNELS(2), .IDX_W(4), .SCORE_W(32),
    .HIT_POINTS(100), .LIVES(3), .TIMEOUT_CYCLES(30)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .photo_array(photo),
    .rand_num(rand_num), .target_idx(target_idx), .target_valid(target_valid),
    .score(score), .lives_left(lives_left), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_edge(input int k);
    while (cyc < base + k) @(negedge clock);
  endtask

  always @(negedge clock) begin
    logic [31:0] es;
    logic [2:0]  el;
    if (!reset && hit_pulse) begin
      if (exp_score_q.size() == 0) check("unexpected_hit_pulse", hit_pulse, 0);
      else begin
        es = exp_score_q.pop_front();
        check("sb_score", score, es);
      end
    end
    if (!reset && miss_pulse) begin
      if (exp_lives_q.size() == 0) check("unexpected_miss_pulse", miss_pulse, 0);
      else begin
        el = exp_lives_q.pop_front();
        check("sb_lives", lives_left, el);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; photo = '1; rand_num = 4'd3;
    repeat (3) @(negedge clock);
    check("rst_score", score, 0);
    check("rst_lives", lives_left, 3);
    check("rst_valid", target_valid, 0);
    check("rst_idx", target_idx, 0);
    check("rst_over", game_over, 0);
    check("rst_pulses", {hit_pulse, miss_pulse}, 0);
    reset = 1'b0;
    @(negedge clock);

    start = 1'b1; base = cyc;
    at_edge(1); check("play_entry_valid", target_valid, 2'b00); start = 1'b0;
    at_edge(2); check("ch0_valid", target_valid, 2'b01); check("ch0_idx", target_idx[3:0], 3);
    at_edge(3); check("ch1_valid", target_valid, 2'b11); check("ch1_bump_idx", target_idx[7:4], 4);

    photo[3] = 1'b0; exp_score_q.push_back(100);
    at_edge(6); check("latency_not_early", score, 0);
    at_edge(7); check("hit_score", score, 100); check("hit_pulse", hit_pulse, 1);
    check("hit_clears_ch0", target_valid, 2'b10);
    rand_num = 4'd13;
    at_edge(8); check("hit_pulse_single", hit_pulse, 0);
    check("fold_valid", target_valid, 2'b11); check("fold_idx", target_idx[3:0], 3);

    photo[4] = 1'b0; exp_score_q.push_back(200);
    at_edge(12); check("held_low_once_score", score, 200);
    rand_num = 4'd9;
    at_edge(13); check("ch1_idx9", target_idx[7:4], 9);
    photo[3] = 1'b1; photo[4] = 1'b1;
    at_edge(15); photo[3] = 1'b0; exp_score_q.push_back(300);
    at_edge(17); photo[3] = 1'b1;
    at_edge(19); check("third_hit_score", score, 300);
    at_edge(20); check("wrap_idx", target_idx[3:0], 0); check("wrap_valid", target_valid, 2'b11);

    photo[0] = 1'b0; photo[9] = 1'b0; exp_score_q.push_back(500);
    at_edge(22); photo[0] = 1'b1; photo[9] = 1'b1;
    at_edge(24); check("double_hit_score", score, 500); check("double_hit_pulse", hit_pulse, 1);
    check("double_hit_clear", target_valid, 2'b00);
    rand_num = 4'd5;
    at_edge(25); check("double_hit_one_pulse", hit_pulse, 0); check("re_idx0", target_idx[3:0], 5);
    at_edge(26); check("re_idx1", target_idx[7:4], 6);

    at_edge(51); photo[5] = 1'b0; exp_score_q.push_back(600);
    at_edge(53); photo[5] = 1'b1;
    exp_lives_q.push_back(2);
    at_edge(55); check("coincide_score", score, 600); check("coincide_lives", lives_left, 3);
    check("coincide_no_miss", miss_pulse, 0);
    exp_lives_q.push_back(1); exp_lives_q.push_back(0);
    at_edge(56); check("miss_lives", lives_left, 2); check("miss_pulse", miss_pulse, 1);
    check("miss_valid", target_valid, 2'b01);
    at_edge(86); check("miss2_lives", lives_left, 1); check("miss2_not_over", game_over, 0);
    at_edge(87); check("final_lives", lives_left, 0); check("final_over", game_over, 1);
    check("final_valid", target_valid, 0);

    photo = '0;
    repeat (6) @(negedge clock);
    check("over_score_frozen", score, 600);
    check("over_valid", target_valid, 0);
    check("over_held", game_over, 1);
    photo = '1;
    repeat (4) @(negedge clock);

    rand_num = 4'd2; start = 1'b1; base = cyc;
    at_edge(1); start = 1'b0;
    check("restart_score", score, 0); check("restart_lives", lives_left, 3);
    check("restart_over", game_over, 0);
    at_edge(2); check("restart_idx0", target_idx[3:0], 2);
    at_edge(3); check("restart_idx1", target_idx[7:4], 3); check("restart_valid", target_valid, 2'b11);
    photo[2] = 1'b0; exp_score_q.push_back(100);
    at_edge(5); photo[2] = 1'b1;
    at_edge(7); check("restart_hit_score", score, 100);

    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_score", score, 0);
    check("async_rst_valid", target_valid, 0);
    check("async_rst_lives", lives_left, 3);
    check("async_rst_over", game_over, 0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_stays_valid", target_valid, 0);
    check("idle_stays_score", score, 0);

    check("sb_score_drained", exp_score_q.size(), 0);
    check("sb_lives_drained", exp_lives_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
